line_timing_counter: RTL

Parametrised vertical line counter for the display adaptor. It is the successor to the plain line counter. It counts lines on increment requests from the display controller and wraps automatically at the end of the frame. It decodes the vertical timing regions (active, front porch, sync, back porch) with a small state machine and produces registered VActive, VSync and end-of-frame outputs for the sync generator and the pixel datapath.

---
 rtl/line_timing_counter.sv | 82 ++++++++
 1 files changed

// File: rtl/line_timing_counter.sv
// Vertical line counter with registered timing-region decode (active, front porch,
// sync, back porch), VSync/VActive strobes and an end-of-frame pulse.
module line_timing_counter #(
    parameter int WIDTH    = 10,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic             clock,
    input  logic             ResetN,
    input  logic             ResetLine,
    input  logic             IncLine,
    output logic [WIDTH-1:0] LineOut,
    output logic [1:0]       Region,
    output logic             VActive,
    output logic             VSync,
    output logic             FrameEnd
);

    localparam int TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FRONT  = 2'd1;
    localparam logic [1:0] ST_SYNC   = 2'd2;
    localparam logic [1:0] ST_BACK   = 2'd3;

    // One extra bit so a boundary equal to TOTAL (zero back porch) cannot alias to 0.
    localparam logic [WIDTH:0] B_FRONT = (WIDTH+1)'(V_ACTIVE);
    localparam logic [WIDTH:0] B_SYNC  = (WIDTH+1)'(V_ACTIVE + V_FP);
    localparam logic [WIDTH:0] B_BACK  = (WIDTH+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(TOTAL - 1);
    localparam logic POL = (SYNC_POL != 0);

    if (TOTAL > (1 << WIDTH)) begin : gWidthCheck
        $error("line_timing_counter: TOTAL exceeds 2**WIDTH");
    end

    logic [WIDTH-1:0] lineNext;
    logic [1:0]       regionNext;
    logic             frameEndNext;

    always_comb begin
        lineNext     = LineOut;
        regionNext   = Region;
        frameEndNext = 1'b0;
        if (ResetLine) begin
            lineNext   = '0;
            regionNext = ST_ACTIVE;
        end else if (IncLine) begin
            if (LineOut == LAST) begin
                lineNext     = '0;
                regionNext   = ST_ACTIVE;
                frameEndNext = 1'b1;
            end else begin
                lineNext = LineOut + WIDTH'(1);
                // Ordered so coincident boundaries (empty regions) land on the later region.
                if ({1'b0, lineNext} == B_FRONT) regionNext = ST_FRONT;
                if ({1'b0, lineNext} == B_SYNC)  regionNext = ST_SYNC;
                if ({1'b0, lineNext} == B_BACK)  regionNext = ST_BACK;
            end
        end
    end

    always_ff @(posedge clock or negedge ResetN) begin
        if (!ResetN) begin
            LineOut  <= '0;
            Region   <= ST_ACTIVE;
            VActive  <= 1'b1;
            VSync    <= ~POL;
            FrameEnd <= 1'b0;
        end else begin
            LineOut  <= lineNext;
            Region   <= regionNext;
            VActive  <= (regionNext == ST_ACTIVE);
            VSync    <= (regionNext == ST_SYNC) ? POL : ~POL;
            FrameEnd <= frameEndNext;
        end
    end

endmodule
